// File: rtl/midi_message_decoder.sv
// MIDI byte-stream parser: turns UART bytes into note_vol, vibrato_level and
// wave_select for a monophonic voice. Supports running status, transparent
// real-time bytes and a channel filter (optionally omni).
module midi_message_decoder #(
    parameter int unsigned MIDI_CHANNEL = 0,
    parameter bit          OMNI         = 1'b0,
    parameter int unsigned VIB_CC       = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [15:0] note_vol,
    output logic [7:0]  vibrato_level,
    output logic [1:0]  wave_select,
    output logic        msg_strobe
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = 7;
    localparam int unsigned NV_W   = 16;

    localparam logic [3:0]        CHAN        = 4'(MIDI_CHANNEL);
    localparam logic [DATA_W-1:0] VIB_NUM     = DATA_W'(VIB_CC);
    localparam logic [DATA_W-1:0] CC_ALL_OFF  = 7'd123;
    localparam logic [BYTE_W-1:0] VIB_RESET   = 8'd64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } state_e;

    state_e              state_q;
    logic [BYTE_W-1:0]   status_q;
    logic [DATA_W-1:0]   d1_q;
    logic [NV_W-1:0]     note_vol_q, note_vol_d;
    logic [BYTE_W-1:0]   vib_q, vib_d;
    logic [1:0]          wave_q, wave_d;
    logic                strobe_q, strobe_d;

    logic                short_msg;
    logic                msg_done;
    logic                chan_ok;
    logic                note_off_ok;
    logic [DATA_W-1:0]   md1;
    logic [DATA_W-1:0]   md2;
    logic [NV_W-1:0]     released;

    // Detect message completion and compute the effect of the executed message
    always_comb begin
        note_vol_d  = note_vol_q;
        vib_d       = vib_q;
        wave_d      = wave_q;
        strobe_d    = 1'b0;
        short_msg   = (status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD);
        msg_done    = rx_valid && !rx_byte[7] &&
                      (((state_q == WAIT_D1) && short_msg) || (state_q == WAIT_D2));
        md1         = (state_q == WAIT_D2) ? d1_q : rx_byte[DATA_W-1:0];
        md2         = rx_byte[DATA_W-1:0];
        chan_ok     = OMNI || (status_q[3:0] == CHAN);
        note_off_ok = note_vol_q[15] && (md1 == note_vol_q[14:8]);
        released    = {1'b0, note_vol_q[14:8], 8'h00};

        if (msg_done && chan_ok) begin
            case (status_q[7:4])
                4'h8: begin
                    if (note_off_ok) begin
                        note_vol_d = released;
                        strobe_d   = 1'b1;
                    end
                end
                4'h9: begin
                    if (md2 != '0) begin
                        note_vol_d = {1'b1, md1, md2, 1'b0};
                        strobe_d   = 1'b1;
                    end else if (note_off_ok) begin
                        note_vol_d = released;
                        strobe_d   = 1'b1;
                    end
                end
                4'hB: begin
                    if (md1 == VIB_NUM) begin
                        vib_d    = {1'b0, md2};
                        strobe_d = 1'b1;
                    end else if (md1 == CC_ALL_OFF) begin
                        note_vol_d = released;
                        strobe_d   = 1'b1;
                    end
                end
                4'hC: begin
                    wave_d   = md1[1:0];
                    strobe_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Byte classifier / message-length FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            status_q   <= '0;
            d1_q       <= '0;
            note_vol_q <= '0;
            vib_q      <= VIB_RESET;
            wave_q     <= '0;
            strobe_q   <= 1'b0;
        end else begin
            note_vol_q <= note_vol_d;
            vib_q      <= vib_d;
            wave_q     <= wave_d;
            strobe_q   <= strobe_d;
            // Real-time bytes (F8..FF) fall through untouched
            if (rx_valid && (rx_byte < 8'hF8)) begin
                if (rx_byte >= 8'hF0) begin
                    status_q <= '0;
                    d1_q     <= '0;
                    state_q  <= IDLE;
                end else if (rx_byte[7]) begin
                    status_q <= rx_byte;
                    d1_q     <= '0;
                    state_q  <= WAIT_D1;
                end else begin
                    case (state_q)
                        WAIT_D1: begin
                            d1_q    <= rx_byte[DATA_W-1:0];
                            state_q <= short_msg ? WAIT_D1 : WAIT_D2;
                        end
                        WAIT_D2: state_q <= WAIT_D1;
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign note_vol      = note_vol_q;
    assign vibrato_level = vib_q;
    assign wave_select   = wave_q;
    assign msg_strobe    = strobe_q;

endmodule

// File: doc/midi_message_decoder.md
Name: midi_message_decoder

Overview:
- Parses the serial MIDI byte stream from the UART receiver into the control words the synth voice consumes: note_vol, vibrato_level and wave_select.
- Sits between the MIDI UART byte receiver and waveform_generator. It is the producing end of the note_vol and vibrato_level interface.
- Monophonic. The most recent Note On owns the voice.

Parameters:
- MIDI_CHANNEL, default 0: 4-bit channel number the block responds to (0 = MIDI channel 1).
- OMNI, default 0: when 1, channel-voice messages on every channel are accepted and MIDI_CHANNEL is ignored.
- VIB_CC, default 1: controller number that drives vibrato_level (1 = mod wheel).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_byte  in  8  received MIDI byte; valid only while rx_valid=1.
- rx_valid  in  1  single-cycle strobe per received byte.
- note_vol  out  16  [15]=gate, [14:8]=note number, [7:0]=volume.
- vibrato_level  out  8  vibrato control; 64 = no vibrato.
- wave_select  out  2  waveform select.
- msg_strobe  out  1  one-cycle pulse whenever an accepted message updates any output.

Behaviour:
- Reset (reset=0, asynchronous): note_vol=16'h0000, vibrato_level=8'd64, wave_select=2'b00, msg_strobe=0, FSM=IDLE, running status cleared.
- Bytes are processed only on cycles with rx_valid=1.
- Latency: outputs and msg_strobe update on the clk edge that samples the message's final byte, so they are visible the cycle after that rx_valid.
- Byte classes:
  - rx_byte>=8'hF8 (real-time): ignored entirely. FSM state, stored bytes and running status are unchanged, so it may fall mid-message.
  - 8'hF0..8'hF7 (system common/SysEx): clears running status, FSM->IDLE. Data bytes that follow are ignored until the next status byte.
  - 8'h80..8'hEF: latches the status (running status), clears partial data, FSM->WAIT_D1. This aborts any incomplete message; the aborted message has no effect.
  - Data bytes (bit7=0) in IDLE: ignored.
- FSM states: IDLE, WAIT_D1, WAIT_D2.
  - WAIT_D1 + data byte: store as d1. For status Cx/Dx the message is complete; execute and go to WAIT_D1. Otherwise go to WAIT_D2.
  - WAIT_D2 + data byte: store as d2, execute, go to WAIT_D1. Running status allows the next data byte to start a new message.
- Channel filter: a message whose status low nibble != MIDI_CHANNEL, with OMNI=0, is still parsed for length but not executed, and msg_strobe stays 0.
- Execution:
  - Note On (9x), d2!=0: note_vol <= {1'b1, d1, d2, 1'b0}, i.e. volume = velocity<<1.
  - Note On with d2=0: treated as Note Off.
  - Note Off (8x): only if gate=1 and d1==note_vol[14:8], set note_vol <= {1'b0, note_vol[14:8], 8'h00}. A non-matching Note Off is ignored, with no strobe.
  - Control Change (Bx) with d1==VIB_CC: vibrato_level <= {1'b0, d2}. Other controller numbers are ignored.
  - CC 123 (all notes off): note_vol <= {1'b0, note_vol[14:8], 8'h00}.
  - Program Change (Cx): wave_select <= d1[1:0].
  - Ax, Dx, Ex: consumed and discarded.
- msg_strobe is 1 for exactly one cycle per executed message that changed or rewrote an output. It is 0 otherwise.
- Simultaneous events: only one byte per cycle by construction. A Note On while gate=1 retriggers with the new note and volume (last-note priority).
- Reset mid-message discards the partial message and clears running status.

Test Plan:
- Reset release, no input -> note_vol=0000, vibrato_level=64, wave_select=0, msg_strobe never asserted.
- Bytes 90 3C 64 -> cycle after last rx_valid: note_vol=16'hBCC8, one msg_strobe pulse. Then running-status bytes 3C 00 -> note_vol=16'h3C00.
- 90 3C 64, then 80 40 10 -> no change (note mismatch), no strobe. Then 80 3C 10 -> note_vol=16'h3C00.
- 90 3C, then F8, then 64 -> note_vol=16'hBCC8 (real-time byte transparent). Then 90 3C, then B0, then 01 7F -> note unaffected, vibrato_level=8'h7F.
- MIDI_CHANNEL=0, OMNI=0: 91 40 7F -> no change, no strobe. C0 02 -> wave_select=2. F0 01 02 F7, then 40 -> all ignored, FSM IDLE.
- 90 3C 64 with reset pulsed low between 3C and 64 (asynchronous, mid-cycle), then 64 -> outputs at reset values, trailing 64 ignored.
